load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, SHALL set the number of cycles a bus beat waits for BUS_Ack before it is aborted.
REQ-002 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 RST_N  in  1  reset, synchronous, active-low.
REQ-004 MEM_Req  in  1  memory-stage instruction is a load/store; held stable with all request inputs while LSU_Stall=1.
REQ-005 MEM_W_En  in  1  1=store, 0=load.
REQ-006 MEM_Control  in  3  access size/sign, using the shared definitions encodings (MEM_BYTE, MEM_BYTE_UNSIGNED, MEM_HALFWORD, MEM_HALFWORD_UNSIGNED, MEM_WORD).
REQ-007 ALU_Out  in  32  byte address.
REQ-008 REG_R_Data2  in  32  store data, right-aligned.
REQ-009 Data_Out  out  32  load result, extended per MEM_Control.
REQ-010 LSU_Stall  out  1  freeze pipeline.
REQ-011 LSU_Done  out  1  one-cycle pulse: access complete, Data_Out valid.
REQ-012 LSU_Fault  out  1  one-cycle pulse: access aborted on timeout.
REQ-013 BUS_Req  out  1, BUS_Addr  out  30 (word address), BUS_W_En  out  1, BUS_Byte_En  out  4, BUS_W_Data  out  32: initiator side of the data bus.
REQ-014 BUS_Ack  in  1, BUS_R_Data  in  32: responder side; BUS_R_Data valid in the BUS_Ack cycle.

Function
REQ-015 FSM states SHALL be IDLE, BEAT0, BEAT1, DONE.
REQ-016 IDLE with MEM_Req=1: latch request, go to BEAT0; LSU_Stall=1 combinationally in that cycle.
REQ-017 LSU_Stall SHALL be 1 in BEAT0/BEAT1, and 0 in IDLE (MEM_Req=0) and DONE.
REQ-018 Bus handshake: BUS_Req held high with Addr/W_En/Byte_En/W_Data stable until a cycle where BUS_Ack=1; beat completes at that edge.
REQ-019 Lane mapping: byte offset o=addr[1:0]; BUS_Byte_En = size mask shifted left by o; BUS_W_Data = store data shifted left by 8*o.
REQ-020 Misaligned access (halfword with o=3, word with o!=0) SHALL split: BEAT0 at addr[31:2], remaining lanes in BEAT1 at addr[31:2]+1 (wrap at 2^30).
REQ-021 Aligned access: BEAT0 -> DONE; split access: BEAT0 -> BEAT1 -> DONE.
REQ-022 Loads SHALL assemble bytes from both beats, then sign/zero extend per MEM_Control.
REQ-023 DONE: LSU_Done=1, Data_Out valid (0 for stores), MEM_Req ignored; next state IDLE.
REQ-024 Data_Out SHALL hold its value until the next DONE.
REQ-025 Timeout counter SHALL reset at each beat start; on reaching TIMEOUT_CYCLES without BUS_Ack, drop BUS_Req, pulse LSU_Fault, go to DONE with LSU_Done=0 and Data_Out=0.
REQ-026 Invalid MEM_Control SHALL complete in DONE without a bus access, Data_Out=0.
REQ-027 A split store whose BEAT1 times out SHALL not retract BEAT0 (partial store permitted, flagged by LSU_Fault).

Reset
REQ-028 RST_N=0 at an edge SHALL force IDLE, clear counter, all outputs 0, including mid-beat (BUS_Req drops next cycle).

Structure
REQ-029 LSU state enum and byte-enable mask constants SHALL live in the definitions package.
REQ-030 Lane shift/extend logic SHALL be one sub-module, lsu_align.

Verification
REQ-031 LW 0x100, BUS_Ack after 2 cycles, R_Data 0xDEADBEEF -> Byte_En 1111, Data_Out 0xDEADBEEF, LSU_Done one cycle.
REQ-032 SB 0x103, data 0x000000A5 -> Byte_En 1000, W_Data 0xA5000000, single beat.
REQ-033 LH 0x103, beats return 0x80xxxxxx then 0xxxxxxxFF -> Addr 0x40 then 0x41, Data_Out 0xFFFFFF80.
REQ-034 LBU 0x001, R_Data 0x0000F000 -> Data_Out 0x000000F0.
REQ-035 No BUS_Ack for 256 cycles -> LSU_Fault pulse, LSU_Stall releases, BUS_Req low.
REQ-036 RST_N low during BEAT1 -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state type and per-size byte-enable masks.
package load_store_unit_pkg;

    localparam logic [2:0] MEM_BYTE              = 3'b000;
    localparam logic [2:0] MEM_HALFWORD          = 3'b001;
    localparam logic [2:0] MEM_WORD              = 3'b010;
    localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
    localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_BEAT0 = 2'd1,
        LSU_BEAT1 = 2'd2,
        LSU_DONE  = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Unaligned lane mask for an access size; BE_NONE marks an invalid encoding.
    function automatic logic [3:0] size_mask(input logic [2:0] ctrl);
        case (ctrl)
            MEM_BYTE, MEM_BYTE_UNSIGNED:         size_mask = BE_BYTE;
            MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: size_mask = BE_HALF;
            MEM_WORD:                            size_mask = BE_WORD;
            default:                             size_mask = BE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the LSU: store data/enables spread over two beats,
// load bytes gathered from two beats and sign/zero extended.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [2:0]  ctrl_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rd_lo_i,
    input  logic [23:0] rd_hi_i,
    output logic [3:0]  be_lo_o,
    output logic [3:0]  be_hi_o,
    output logic [31:0] wd_lo_o,
    output logic [31:0] wd_hi_o,
    output logic [31:0] ld_data_o,
    output logic        split_o
);

    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [31:0] ld_word;

    always_comb begin
        be_wide = {4'b0000, size_mask(ctrl_i)} << offset_i;
        wd_wide = {32'h0, st_data_i} << {offset_i, 3'b000};
    end

    assign be_lo_o = be_wide[3:0];
    assign be_hi_o = be_wide[7:4];
    assign wd_lo_o = wd_wide[31:0];
    assign wd_hi_o = wd_wide[63:32];
    assign split_o = |be_wide[7:4];

    // Bytes past the end of the first word come from the low lanes of the second.
    always_comb begin
        case (offset_i)
            2'd0:    ld_word = rd_lo_i;
            2'd1:    ld_word = {rd_hi_i[7:0],  rd_lo_i[31:8]};
            2'd2:    ld_word = {rd_hi_i[15:0], rd_lo_i[31:16]};
            default: ld_word = {rd_hi_i[23:0], rd_lo_i[31:24]};
        endcase
    end

    always_comb begin
        case (ctrl_i)
            MEM_BYTE:              ld_data_o = {{24{ld_word[7]}}, ld_word[7:0]};
            MEM_BYTE_UNSIGNED:     ld_data_o = {24'h0, ld_word[7:0]};
            MEM_HALFWORD:          ld_data_o = {{16{ld_word[15]}}, ld_word[15:0]};
            MEM_HALFWORD_UNSIGNED: ld_data_o = {16'h0, ld_word[15:0]};
            MEM_WORD:              ld_data_o = ld_word;
            default:               ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a memory-stage request into one or two bus beats
// with per-beat ack timeout, then reports completion or fault for one cycle.
//
//   state | meaning
//   IDLE  | waiting for MEM_Req; latches the request
//   BEAT0 | first bus beat at addr[31:2]
//   BEAT1 | second beat of a split access at addr[31:2]+1
//   DONE  | result valid, LSU_Done or LSU_Fault pulse
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MEM_Req,
    input  logic        MEM_W_En,
    input  logic [2:0]  MEM_Control,
    input  logic [31:0] ALU_Out,
    input  logic [31:0] REG_R_Data2,
    output logic [31:0] Data_Out,
    output logic        LSU_Stall,
    output logic        LSU_Done,
    output logic        LSU_Fault,
    output logic        BUS_Req,
    output logic [29:0] BUS_Addr,
    output logic        BUS_W_En,
    output logic [3:0]  BUS_Byte_En,
    output logic [31:0] BUS_W_Data,
    input  logic        BUS_Ack,
    input  logic [31:0] BUS_R_Data
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          we_q, we_d;
    logic [31:0]   rd0_q, rd0_d;
    logic [31:0]   data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;

    logic [3:0]    be_lo, be_hi;
    logic [31:0]   wd_lo, wd_hi, ld_data, rd_lo;
    logic          split;

    // The final beat's read data is used live in its ack cycle.
    assign rd_lo = (state_q == LSU_BEAT0) ? BUS_R_Data : rd0_q;

    lsu_align u_align (
        .offset_i  (addr_q[1:0]),
        .ctrl_i    (ctrl_q),
        .st_data_i (wdata_q),
        .rd_lo_i   (rd_lo),
        .rd_hi_i   (BUS_R_Data[23:0]),
        .be_lo_o   (be_lo),
        .be_hi_o   (be_hi),
        .wd_lo_o   (wd_lo),
        .wd_hi_o   (wd_hi),
        .ld_data_o (ld_data),
        .split_o   (split)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ctrl_d      = ctrl_q;
        we_d        = we_q;
        rd0_d       = rd0_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        fault_d     = 1'b0;
        LSU_Stall   = 1'b0;
        LSU_Done    = 1'b0;
        LSU_Fault   = 1'b0;
        BUS_Req     = 1'b0;
        BUS_Addr    = 30'h0;
        BUS_W_En    = 1'b0;
        BUS_Byte_En = 4'h0;
        BUS_W_Data  = 32'h0;

        case (state_q)
            LSU_IDLE: begin
                if (MEM_Req) begin
                    LSU_Stall = 1'b1;
                    addr_d    = ALU_Out;
                    wdata_d   = REG_R_Data2;
                    ctrl_d    = MEM_Control;
                    we_d      = MEM_W_En;
                    cnt_d     = CNT_LOAD;
                    if (size_mask(MEM_Control) == BE_NONE) begin
                        data_d  = 32'h0;
                        state_d = LSU_DONE;
                    end else begin
                        state_d = LSU_BEAT0;
                    end
                end
            end
            LSU_BEAT0: begin
                LSU_Stall   = 1'b1;
                BUS_Req     = 1'b1;
                BUS_Addr    = addr_q[31:2];
                BUS_W_En    = we_q;
                BUS_Byte_En = be_lo;
                BUS_W_Data  = wd_lo;
                if (BUS_Ack) begin
                    rd0_d = BUS_R_Data;
                    if (split) begin
                        cnt_d   = CNT_LOAD;
                        state_d = LSU_BEAT1;
                    end else begin
                        data_d  = we_q ? 32'h0 : ld_data;
                        state_d = LSU_DONE;
                    end
                end else if (cnt_q == '0) begin
                    fault_d = 1'b1;
                    data_d  = 32'h0;
                    state_d = LSU_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LSU_BEAT1: begin
                LSU_Stall   = 1'b1;
                BUS_Req     = 1'b1;
                BUS_Addr    = addr_q[31:2] + 30'd1;
                BUS_W_En    = we_q;
                BUS_Byte_En = be_hi;
                BUS_W_Data  = wd_hi;
                if (BUS_Ack) begin
                    data_d  = we_q ? 32'h0 : ld_data;
                    state_d = LSU_DONE;
                end else if (cnt_q == '0) begin
                    // The first beat of a split store has already landed; only flag it.
                    fault_d = 1'b1;
                    data_d  = 32'h0;
                    state_d = LSU_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LSU_DONE: begin
                LSU_Done  = ~fault_q;
                LSU_Fault = fault_q;
                state_d   = LSU_IDLE;
            end
        endcase
    end

    assign Data_Out = data_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= LSU_IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ctrl_q  <= 3'h0;
            we_q    <= 1'b0;
            rd0_q   <= 32'h0;
            data_q  <= 32'h0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            we_q    <= we_d;
            rd0_q   <= rd0_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

endmodule
